fa16_rev_bennett_seq: RTL and testbench
=======================================

FA16_REV_BENNETT_SEQ -- requirements
Module: fa16_rev_bennett_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the LIFO entry count (2..16).
REQ-002 SHALL have parameter SETTLE_CYC, default 2, the cycles the adder is driven before it is sampled (>=1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 16), in_b (input, 16) and in_c0 (input, 1): the compute request.
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_s (output, 16) and out_c15 (output, 1): the compute result.
REQ-007 SHALL have ports unc_valid (input, 1) and unc_ready (output, 1): the uncompute request, which pops the newest LIFO entry.
REQ-008 SHALL have ports unc_done (output, 1-cycle pulse), unc_a (output, 16), unc_b (output, 16), unc_c0 (output, 1) and unc_ok (output, 1): the recovered inputs and the check result.
REQ-009 SHALL have ports dir (output, 1), f_a/f_b (output, 16), f_c0_f/f_z (output, 1), f_s/f_a_b (input, 16) and f_c0_b/f_c15 (input, 1): the forward side of the fa16_rev adder.
REQ-010 SHALL have ports r_s/r_a_b (output, 16), r_c0_b/r_c15 (output, 1), r_a/r_b (input, 16) and r_c0_f/r_z (input, 1): the backward side of the adder.
REQ-011 SHALL have ports level (output, clog2(DEPTH+1)), full (output, 1) and empty (output, 1): the LIFO status.

Function
REQ-012 SHALL implement FSM states IDLE, TURN, FWD_WAIT, OUT_HOLD, BWD_WAIT and UNC_PULSE.
REQ-013 SHALL drive in_ready = (state==IDLE) && !full && !(unc_valid && !empty), so that uncompute has priority when both requests are valid.
REQ-014 SHALL drive unc_ready = (state==IDLE) && !empty.
REQ-015 SHALL, on compute accept, register in_a, in_b and in_c0 onto f_a, f_b and f_c0_f, with f_z always 0.
REQ-016 SHALL go to FWD_WAIT if dir==0, otherwise to TURN.
REQ-017 SHALL, in TURN, spend 1 cycle setting dir to the target direction, then enter FWD_WAIT or BWD_WAIT.
REQ-018 SHALL, in FWD_WAIT, count SETTLE_CYC cycles, then push {f_s, f_a_b, f_c0_b, f_c15} onto the LIFO, load out_s and out_c15, and enter OUT_HOLD.
REQ-019 SHALL give a compute latency from accept cycle T to out_valid of T+SETTLE_CYC+1 when dir==0, plus 1 cycle when a TURN is needed.
REQ-020 SHALL, in OUT_HOLD, hold out_valid=1 with stable data until out_ready, then return to IDLE with out_valid=0 on the next cycle.
REQ-021 SHALL, on uncompute accept, pop the top entry onto r_s, r_a_b, r_c0_b and r_c15, then go through TURN (if dir==0) and BWD_WAIT for SETTLE_CYC cycles.
REQ-022 SHALL then capture r_a, r_b and r_c0_f into unc_a, unc_b and unc_c0, and pulse unc_done for 1 cycle in UNC_PULSE.
REQ-023 SHALL flag an error if r_z != 0 on capture, and SHALL then drive unc_ok=0.
REQ-024 SHALL hold dir after an operation completes; dir changes only in TURN.
REQ-025 SHALL keep level, full (level==DEPTH) and empty (level==0) registered; the push in REQ-018 increments level and the pop in REQ-021 decrements it.
REQ-026 SHALL never push when full and never pop when empty; the handshakes in REQ-013 and REQ-014 guarantee this.
REQ-027 SHALL keep the LIFO pointer from wrapping: push at level==DEPTH and pop at level==0 are unreachable, and an assertion fires if either occurs.

Reset
REQ-028 SHALL, on rst, force state=IDLE and dir=0.
REQ-029 SHALL, on rst, clear every f_* and r_* output register, out_s, out_c15, unc_a, unc_b, unc_c0 and level to 0.
REQ-030 SHALL, on rst, force out_valid=0, unc_done=0, unc_ok=1, empty=1 and full=0.
REQ-031 SHALL, when rst arrives mid-operation, abandon the operation, discard the LIFO contents and produce no completion.

Configuration
REQ-032 SHALL, with FA16_REV_CHECK_EN defined, store {in_a, in_b, in_c0} with each entry and set unc_ok = (recovered == stored) && (r_z==0).
REQ-033 SHALL, without FA16_REV_CHECK_EN, store no originals and set unc_ok = (r_z==0) only.

Structure
REQ-034 SHALL place the state enum, the entry struct (s, a_b, c0_b, c15, and the optional originals) and the width localparams in the package fa16_rev_pkg.
REQ-035 SHALL implement the LIFO as sub-module fa16_rev_lifo (push, pop, data, level), and this module SHALL instantiate it.

Verification
REQ-036 SHALL cover: dir=0 idle, compute a=0x1234, b=0x0FF0, c0=0 -> out_s=0x2224 and out_c15=0 at T+3 with the default SETTLE_CYC; level=1.
REQ-037 SHALL cover: compute 0xFFFF+0x0001 with c0=1 -> out_s=0x0001 and out_c15=1; then uncompute -> TURN cycle, unc_a=0xFFFF, unc_b=0x0001, unc_c0=1, unc_ok=1.
REQ-038 SHALL cover: 4 computes fill the LIFO -> full=1 and in_ready=0; 4 uncomputes -> recovered operands in reverse order, empty=1 and unc_ready=0.
REQ-039 SHALL cover: in_valid and unc_valid both high in IDLE with level=2 -> uncompute accepted first, and compute accepted afterwards.
REQ-040 SHALL cover: out_ready held low for 5 cycles -> out_valid and data stable and in_ready=0 throughout.
REQ-041 SHALL cover: rst asserted in BWD_WAIT -> no unc_done, level=0 and dir=0 next cycle; and with CHECK_EN, r_a corrupted by the bench -> unc_ok=0.

Source files
------------

// File: rtl/fa16_rev_pkg.sv
//==============================================================================
// fa16_rev_pkg : shared types for the fa16_rev Bennett sequencer and its LIFO
// Rev 1.0
//==============================================================================
`default_nettype none

package fa16_rev_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TURN      = 3'd1,
      FWD_WAIT  = 3'd2,
      OUT_HOLD  = 3'd3,
      BWD_WAIT  = 3'd4,
      UNC_PULSE = 3'd5
   } state_t;

   // One history entry: everything the backward adder needs to run in reverse
   typedef struct packed {
      logic [DATA_W-1:0] s;
      logic [DATA_W-1:0] a_b;
      logic              c0_b;
      logic              c15;
`ifdef FA16_REV_CHECK_EN
      logic [DATA_W-1:0] orig_a;
      logic [DATA_W-1:0] orig_b;
      logic              orig_c0;
`endif
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/fa16_rev_lifo.sv
//==============================================================================
// fa16_rev_lifo : history stack of forward-pass results, newest entry on top
// Rev 1.0
//==============================================================================
`default_nettype none

module fa16_rev_lifo
   import fa16_rev_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  entry_t        push_data,
   output entry_t        pop_data,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx   = AW'(level);
   assign rd_idx   = AW'(level - LW'(1));
   assign pop_data = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= push_data;
      end
   end

   // Reset only rewinds the pointer; stale storage is unreachable afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else if (push && !pop) begin
         level <= level + LW'(1);
         full  <= (level + LW'(1)) == LW'(DEPTH);
         empty <= 1'b0;
      end else if (pop && !push) begin
         level <= level - LW'(1);
         full  <= 1'b0;
         empty <= level == LW'(1);
      end
   end

   a_no_push_full : assert property (@(posedge clk) disable iff (rst)
      !(push && (level == LW'(DEPTH))));

   a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
      !(pop && (level == '0)));

endmodule

`default_nettype wire

// File: rtl/fa16_rev_bennett_seq.sv
//==============================================================================
// fa16_rev_bennett_seq : compute/uncompute sequencer around a reversible adder.
// Rev 1.0 -- define FA16_REV_CHECK_EN to store operands and verify round trips
//==============================================================================
`default_nettype none

module fa16_rev_bennett_seq
   import fa16_rev_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int SETTLE_CYC = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [15:0]                  in_a,
   input  logic [15:0]                  in_b,
   input  logic                         in_c0,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [15:0]                  out_s,
   output logic                         out_c15,
   input  logic                         unc_valid,
   output logic                         unc_ready,
   output logic                         unc_done,
   output logic [15:0]                  unc_a,
   output logic [15:0]                  unc_b,
   output logic                         unc_c0,
   output logic                         unc_ok,
   output logic                         dir,
   output logic [15:0]                  f_a,
   output logic [15:0]                  f_b,
   output logic                         f_c0_f,
   output logic                         f_z,
   input  logic [15:0]                  f_s,
   input  logic [15:0]                  f_a_b,
   input  logic                         f_c0_b,
   input  logic                         f_c15,
   output logic [15:0]                  r_s,
   output logic [15:0]                  r_a_b,
   output logic                         r_c0_b,
   output logic                         r_c15,
   input  logic [15:0]                  r_a,
   input  logic [15:0]                  r_b,
   input  logic                         r_c0_f,
   input  logic                         r_z,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          target;
   logic          target_nx;
   logic          dir_nx;
   logic          accept_in;
   logic          accept_unc;
   logic          do_push;
   logic          do_cap;
   logic          settled;
   entry_t        push_entry;
   entry_t        pop_entry;

`ifdef FA16_REV_CHECK_EN
   logic [15:0]   held_a;
   logic [15:0]   held_b;
   logic          held_c0;
`endif

   assign in_ready  = (state == IDLE) && !full && !(unc_valid && !empty);
   assign unc_ready = (state == IDLE) && !empty;
   assign out_valid = (state == OUT_HOLD);
   assign unc_done  = (state == UNC_PULSE);
   assign f_z       = 1'b0;
   assign settled   = (cnt == CW'(SETTLE_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         target <= 1'b0;
         dir    <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         target <= target_nx;
         dir    <= dir_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      target_nx  = target;
      dir_nx     = dir;
      accept_in  = 1'b0;
      accept_unc = 1'b0;
      do_push    = 1'b0;
      do_cap     = 1'b0;
      case (state)
         IDLE: begin
            if (unc_valid && unc_ready) begin
               accept_unc = 1'b1;
               target_nx  = 1'b1;
               cnt_nx     = '0;
               state_nx   = dir ? BWD_WAIT : TURN;
            end else if (in_valid && in_ready) begin
               accept_in  = 1'b1;
               target_nx  = 1'b0;
               cnt_nx     = '0;
               state_nx   = dir ? TURN : FWD_WAIT;
            end
         end
         TURN: begin
            dir_nx   = target;
            state_nx = target ? BWD_WAIT : FWD_WAIT;
         end
         FWD_WAIT: begin
            if (settled) begin
               do_push  = 1'b1;
               state_nx = OUT_HOLD;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         OUT_HOLD: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         BWD_WAIT: begin
            if (settled) begin
               do_cap   = 1'b1;
               state_nx = UNC_PULSE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         UNC_PULSE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // f_a/f_b/f_c0_f still hold the operands when the forward result is pushed
   always_comb begin
      push_entry      = '0;
      push_entry.s    = f_s;
      push_entry.a_b  = f_a_b;
      push_entry.c0_b = f_c0_b;
      push_entry.c15  = f_c15;
`ifdef FA16_REV_CHECK_EN
      push_entry.orig_a  = f_a;
      push_entry.orig_b  = f_b;
      push_entry.orig_c0 = f_c0_f;
`endif
   end

   fa16_rev_lifo #(
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_lifo (
      .clk       (clk),
      .rst       (rst),
      .push      (do_push),
      .pop       (accept_unc),
      .push_data (push_entry),
      .pop_data  (pop_entry),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         f_a     <= '0;
         f_b     <= '0;
         f_c0_f  <= 1'b0;
         r_s     <= '0;
         r_a_b   <= '0;
         r_c0_b  <= 1'b0;
         r_c15   <= 1'b0;
         out_s   <= '0;
         out_c15 <= 1'b0;
         unc_a   <= '0;
         unc_b   <= '0;
         unc_c0  <= 1'b0;
         unc_ok  <= 1'b1;
`ifdef FA16_REV_CHECK_EN
         held_a  <= '0;
         held_b  <= '0;
         held_c0 <= 1'b0;
`endif
      end else begin
         if (accept_in) begin
            f_a    <= in_a;
            f_b    <= in_b;
            f_c0_f <= in_c0;
         end
         if (do_push) begin
            out_s   <= f_s;
            out_c15 <= f_c15;
         end
         if (accept_unc) begin
            r_s    <= pop_entry.s;
            r_a_b  <= pop_entry.a_b;
            r_c0_b <= pop_entry.c0_b;
            r_c15  <= pop_entry.c15;
`ifdef FA16_REV_CHECK_EN
            held_a  <= pop_entry.orig_a;
            held_b  <= pop_entry.orig_b;
            held_c0 <= pop_entry.orig_c0;
`endif
         end
         if (do_cap) begin
            unc_a  <= r_a;
            unc_b  <= r_b;
            unc_c0 <= r_c0_f;
`ifdef FA16_REV_CHECK_EN
            unc_ok <= (r_a == held_a) && (r_b == held_b) && (r_c0_f == held_c0) && !r_z;
`else
            unc_ok <= !r_z;
`endif
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fa16_rev_bennett_seq.sv
//==============================================================================
// tb_fa16_rev_bennett_seq : directed bench with a behavioural reversible adder
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_fa16_rev_bennett_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_c0;
   logic [15:0] in_a, in_b;
   logic        out_valid, out_ready, out_c15;
   logic [15:0] out_s;
   logic        unc_valid, unc_ready, unc_done, unc_c0, unc_ok;
   logic [15:0] unc_a, unc_b;
   logic        dir;
   logic [15:0] f_a, f_b, f_s, f_a_b;
   logic        f_c0_f, f_z, f_c0_b, f_c15;
   logic [15:0] r_s, r_a_b, r_a, r_b;
   logic        r_c0_b, r_c15, r_c0_f, r_z;
   logic [2:0]  level;
   logic        full, empty;

   logic [15:0] corrupt_mask;
   logic        force_z;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Behavioural adder: forward keeps a and c0 as garbage, backward recovers b
   logic [16:0] fwd_sum;
   logic [15:0] bwd_b;
   logic [16:0] bwd_chk;
   assign fwd_sum = {1'b0, f_a} + {1'b0, f_b} + {16'd0, f_c0_f};
   assign f_s     = fwd_sum[15:0];
   assign f_c15   = fwd_sum[16];
   assign f_a_b   = f_a;
   assign f_c0_b  = f_c0_f;
   assign bwd_b   = r_s - r_a_b - {15'd0, r_c0_b};
   assign bwd_chk = {1'b0, r_a_b} + {1'b0, bwd_b} + {16'd0, r_c0_b};
   assign r_a     = r_a_b ^ corrupt_mask;
   assign r_b     = bwd_b;
   assign r_c0_f  = r_c0_b;
   assign r_z     = force_z | (bwd_chk != {r_c15, r_s});

   fa16_rev_bennett_seq #(.DEPTH(4), .SETTLE_CYC(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c0(in_c0),
      .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_c15(out_c15),
      .unc_valid(unc_valid), .unc_ready(unc_ready), .unc_done(unc_done),
      .unc_a(unc_a), .unc_b(unc_b), .unc_c0(unc_c0), .unc_ok(unc_ok),
      .dir(dir), .f_a(f_a), .f_b(f_b), .f_c0_f(f_c0_f), .f_z(f_z),
      .f_s(f_s), .f_a_b(f_a_b), .f_c0_b(f_c0_b), .f_c15(f_c15),
      .r_s(r_s), .r_a_b(r_a_b), .r_c0_b(r_c0_b), .r_c15(r_c15),
      .r_a(r_a), .r_b(r_b), .r_c0_f(r_c0_f), .r_z(r_z),
      .level(level), .full(full), .empty(empty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_compute(input logic [15:0] a, input logic [15:0] b, input logic c0,
                             input int lat, input logic [15:0] es, input logic ec);
      int n;
      in_a = a; in_b = b; in_c0 = c0; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL compute_in_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (n != lat) begin errors++; $display("FAIL compute_latency: got %0d expected %0d", n, lat); end
      checks++;
      if (out_s !== es || out_c15 !== ec)
         begin errors++; $display("FAIL compute_result: got %h/%b expected %h/%b", out_s, out_c15, es, ec); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL compute_release: out_valid got %b expected 0", out_valid); end
   endtask

   task automatic do_uncompute(input logic [15:0] ea, input logic [15:0] eb, input logic ec0,
                               input logic eok, input int lat);
      int n;
      unc_valid = 1'b1;
      checks++;
      if (unc_ready !== 1'b1) begin errors++; $display("FAIL unc_ready: got %b expected 1", unc_ready); end
      tick();
      unc_valid = 1'b0;
      n = 1;
      while (unc_done !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (n != lat) begin errors++; $display("FAIL unc_latency: got %0d expected %0d", n, lat); end
      checks++;
      if (unc_a !== ea || unc_b !== eb || unc_c0 !== ec0)
         begin errors++; $display("FAIL unc_operands: got %h %h %b expected %h %h %b", unc_a, unc_b, unc_c0, ea, eb, ec0); end
      checks++;
      if (unc_ok !== eok) begin errors++; $display("FAIL unc_ok: got %b expected %b", unc_ok, eok); end
      tick();
      checks++;
      if (unc_done !== 1'b0) begin errors++; $display("FAIL unc_pulse_width: unc_done got %b expected 0", unc_done); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || unc_done !== 1'b0 || unc_ok !== 1'b1)
         begin errors++; $display("FAIL reset_flags: got ov=%b ud=%b ok=%b expected 0 0 1", out_valid, unc_done, unc_ok); end
      checks++;
      if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || dir !== 1'b0)
         begin errors++; $display("FAIL reset_status: got lvl=%0d e=%b f=%b dir=%b expected 0 1 0 0", level, empty, full, dir); end
      checks++;
      if (f_a !== 16'h0 || f_b !== 16'h0 || f_c0_f !== 1'b0 || f_z !== 1'b0 || r_s !== 16'h0 || r_a_b !== 16'h0 ||
          r_c0_b !== 1'b0 || r_c15 !== 1'b0 || out_s !== 16'h0 || out_c15 !== 1'b0 || unc_a !== 16'h0 || unc_b !== 16'h0 || unc_c0 !== 1'b0)
         begin errors++; $display("FAIL reset_regs: got f_a=%h r_s=%h out_s=%h unc_a=%h expected all zero", f_a, r_s, out_s, unc_a); end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || unc_ready !== 1'b0)
         begin errors++; $display("FAIL reset_ready: got in=%b unc=%b expected 1 0", in_ready, unc_ready); end
   endtask

   task automatic test_basic();
      do_compute(16'h1234, 16'h0FF0, 1'b0, 3, 16'h2224, 1'b0);
      checks++;
      if (level !== 3'd1 || dir !== 1'b0) begin errors++; $display("FAIL basic_level: got lvl=%0d dir=%b expected 1 0", level, dir); end
   endtask

   task automatic test_carry_roundtrip();
      do_compute(16'hFFFF, 16'h0001, 1'b1, 3, 16'h0001, 1'b1);
      do_uncompute(16'hFFFF, 16'h0001, 1'b1, 1'b1, 4);
      checks++;
      if (dir !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL carry_dir: got dir=%b lvl=%0d expected 1 1", dir, level); end
      do_uncompute(16'h1234, 16'h0FF0, 1'b0, 1'b1, 3);
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL carry_empty: got %b expected 1", empty); end
   endtask

   task automatic test_fill_drain();
      do_compute(16'h0001, 16'h0002, 1'b0, 4, 16'h0003, 1'b0);
      do_compute(16'h8000, 16'h8000, 1'b0, 3, 16'h0000, 1'b1);
      do_compute(16'hAAAA, 16'h5555, 1'b1, 3, 16'h0000, 1'b1);
      do_compute(16'h7FFF, 16'h0001, 1'b0, 3, 16'h8000, 1'b0);
      in_valid = 1'b1;
      #1;
      checks++;
      if (full !== 1'b1 || in_ready !== 1'b0 || level !== 3'd4)
         begin errors++; $display("FAIL fill_full: got f=%b in_ready=%b lvl=%0d expected 1 0 4", full, in_ready, level); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (level !== 3'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_blocked: got lvl=%0d ov=%b expected 4 0", level, out_valid); end
      do_uncompute(16'h7FFF, 16'h0001, 1'b0, 1'b1, 4);
      do_uncompute(16'hAAAA, 16'h5555, 1'b1, 1'b1, 3);
      do_uncompute(16'h8000, 16'h8000, 1'b0, 1'b1, 3);
      do_uncompute(16'h0001, 16'h0002, 1'b0, 1'b1, 3);
      checks++;
      if (empty !== 1'b1 || unc_ready !== 1'b0 || level !== 3'd0)
         begin errors++; $display("FAIL drain_empty: got e=%b unc_ready=%b lvl=%0d expected 1 0 0", empty, unc_ready, level); end
   endtask

   task automatic test_priority();
      int n;
      do_compute(16'h0100, 16'h0200, 1'b0, 4, 16'h0300, 1'b0);
      do_compute(16'h0F00, 16'h00F0, 1'b0, 3, 16'h0FF0, 1'b0);
      in_a = 16'h1000; in_b = 16'h2000; in_c0 = 1'b0;
      in_valid = 1'b1; unc_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || unc_ready !== 1'b1)
         begin errors++; $display("FAIL prio_ready: got in=%b unc=%b expected 0 1", in_ready, unc_ready); end
      tick();
      unc_valid = 1'b0;
      n = 1;
      while (unc_done !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (n != 4 || unc_a !== 16'h0F00 || unc_b !== 16'h00F0)
         begin errors++; $display("FAIL prio_unc_first: got lat=%0d %h %h expected 4 0f00 00f0", n, unc_a, unc_b); end
      tick();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_compute_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (n != 4 || out_s !== 16'h3000 || level !== 3'd2)
         begin errors++; $display("FAIL prio_compute_after: got lat=%0d s=%h lvl=%0d expected 4 3000 2", n, out_s, level); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_hold();
      int n;
      logic stable;
      in_a = 16'h4321; in_b = 16'h1111; in_c0 = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (n != 3 || out_s !== 16'h5433 || out_c15 !== 1'b0)
         begin errors++; $display("FAIL hold_first: got lat=%0d s=%h c=%b expected 3 5433 0", n, out_s, out_c15); end
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid !== 1'b1 || out_s !== 16'h5433 || out_c15 !== 1'b0 || in_ready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b expected 1 (ov=%b s=%h in_ready=%b)", stable, out_valid, out_s, in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || level !== 3'd3) begin errors++; $display("FAIL hold_release: got ov=%b lvl=%0d expected 0 3", out_valid, level); end
   endtask

   task automatic test_check();
      logic exp_ok;
`ifdef FA16_REV_CHECK_EN
      exp_ok = 1'b0;
`else
      exp_ok = 1'b1;
`endif
      corrupt_mask = 16'h0004;
      do_uncompute(16'h4325, 16'h1111, 1'b1, exp_ok, 4);
      corrupt_mask = 16'h0000;
      force_z = 1'b1;
      do_uncompute(16'h1000, 16'h2000, 1'b0, 1'b0, 3);
      force_z = 1'b0;
      do_uncompute(16'h0100, 16'h0200, 1'b0, 1'b1, 3);
   endtask

   task automatic test_reset_mid();
      logic seen;
      do_compute(16'h0005, 16'h0006, 1'b0, 4, 16'h000B, 1'b0);
      unc_valid = 1'b1;
      tick();
      unc_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (unc_done !== 1'b0 || level !== 3'd0 || dir !== 1'b0 || empty !== 1'b1)
         begin errors++; $display("FAIL rst_mid_state: got ud=%b lvl=%0d dir=%b e=%b expected 0 0 0 1", unc_done, level, dir, empty); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (unc_done !== 1'b0 || out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || unc_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_completion: got %b/%b expected 0/0", seen, unc_ready); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c0 = 1'b0;
      out_ready = 1'b0; unc_valid = 1'b0; corrupt_mask = '0; force_z = 1'b0;
      test_reset();
      test_basic();
      test_carry_roundtrip();
      test_fill_drain();
      test_priority();
      test_hold();
      test_check();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
